dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the control unit's load/store interface. It accepts a single load or store request, inserts a configurable number of wait states, commits stores with byte-lane masking, and returns sign- or zero-extended load data with a one-cycle `ready` pulse. It sits between the control unit's `addr`/`mem_write`/`wr_en` outputs and its `mem_read` input.

## Interface
- `DEPTH_WORDS`, default 1024: storage depth in 32-bit words; must be a power of 2.
- `WAIT_STATES`, default 1: number of wait cycles between request acceptance and response (0–15).

- `clk`  input  1: single clock; all logic on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `req`  input  1: request strobe; sampled only in IDLE.
- `wr_en`  input  1: 1 = store, 0 = load.
- `addr`  input  32: byte address.
- `mem_write`  input  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `size`  input  2: 00 byte, 01 half, 10 word, 11 treated as word.
- `load_unsigned`  input  1: 1 = zero-extend, 0 = sign-extend; loads only.
- `mem_read`  output  32: load data; valid while `ready`=1, held until the next response.
- `ready`  output  1: one-cycle response pulse for both loads and stores.
- `err`  output  1: misalignment flag; qualified by `ready`.
- `busy`  output  1: high in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE, `req`=1: latch `wr_en`, `addr`, `mem_write`, `size`, `load_unsigned`. Go to WAIT if `WAIT_STATES`>0, otherwise go to RESP.
  - WAIT: count down `WAIT_STATES` cycles, then go to RESP.
  - RESP: `ready`=1 for exactly one cycle, then go to IDLE.
- `req` is ignored in WAIT and RESP. There is no queueing. The initiator must wait for `ready` before issuing the next request.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are dropped, so addresses wrap modulo `DEPTH_WORDS*4`.
- Stores:
  - Byte: write lane `addr[1:0]` with `mem_write[7:0]`.
  - Half: write lanes {`addr[1]`,0} and {`addr[1]`,1} with `mem_write[15:0]`.
  - Word: write all four lanes.
  - Unwritten lanes keep their contents.
- Loads:
  - Select the byte or half using the same lane rules as stores.
  - Sign-extend from bit 7 or bit 15, or zero-extend when `load_unsigned`=1.
  - Word loads ignore `load_unsigned`.
- The store commit and the `mem_read` register update both occur on the clock edge that enters RESP.
- Reset values: state IDLE, `ready`=0, `err`=0, `busy`=0, `mem_read`=0. Memory contents are not cleared.
- Reset in WAIT, or on the edge that would enter RESP: the request is discarded, no store is committed, and no `ready` is generated. `rst` has priority over every transition.

## Timing
- A request sampled at the edge ending cycle N produces `ready`=1 in cycle N+1+`WAIT_STATES`. With the default parameters this is N+2.
- `busy` rises in cycle N+1 and falls after the RESP cycle.
- Maximum throughput is one request per `WAIT_STATES`+2 cycles, because IDLE must be observed before the next request is accepted.
- A store becomes visible to a load accepted in any later IDLE cycle.
- `mem_read` for a store response is unchanged (keeps the previous value), except in the error case, where it is 0.

## Configuration
- Macro `DMEM_MISALIGN_CHECK_EN`.
- Defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - A misaligned access responds with `err`=1 and `mem_read`=0 in the RESP cycle.
  - A misaligned store is suppressed; memory is unchanged.
  - Latency is the same as for an aligned access.
- Not defined:
  - `err` is tied to 0.
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`. The access is forced onto the aligned lanes.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 → `mem_read`=0xDEADBEEF, with `ready` in cycle N+2 after each `req` (WAIT_STATES=1).
- Store byte 0x80 to 0x13, then run three loads:
  - signed byte at 0x13 → 0xFFFFFF80;
  - unsigned byte at 0x13 → 0x00000080;
  - word at 0x10 → 0x80ADBEEF.
- Store half 0x1234 to 0x12, then signed half load from 0x12 → 0x00001234, and word load from 0x10 → 0x1234BEEF.
- With `DMEM_MISALIGN_CHECK_EN`, store half to 0x11 → `err`=1, `mem_read`=0; a following word load from 0x10 returns the unchanged value. Without the macro, the same store writes lanes 0–1.
- Wrap and ignore behaviour with DEPTH_WORDS=1024:
  - load word from 0x1010 → same data as 0x10;
  - a second `req` pulsed while `busy`=1 → exactly one `ready`.
- Assert `rst` during WAIT of a store of 0xCAFEF00D to 0x20 → no `ready`, all outputs 0 next cycle, and a later load from 0x20 returns the old value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES wait cycles, byte-lane stores, extended loads.
// Optional misalignment checking is enabled with the DMEM_MISALIGN_CHECK_EN macro.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] mem_read,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = AW + 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic          accept_s;
    logic          enter_resp_s;
    logic [3:0]    cnt_r;
    logic          wr_en_r;
    logic [BW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [1:0]    size_r;
    logic          unsigned_r;
    logic          ready_r;
    logic          busy_r;
    logic          err_r;
    logic [31:0]   mem_read_r;

    logic          cur_wr_s;
    logic [BW-1:0] cur_addr_s;
    logic [31:0]   cur_wdata_s;
    logic [1:0]    cur_size_s;
    logic          cur_unsigned_s;
    logic [AW-1:0] cur_idx_s;
    logic          misalign_s;
    logic [3:0]    lane_mask_s;
    logic [31:0]   lane_data_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   load_data_s;
    logic          unused_addr_s;

    logic [31:0]   mem_r [DEPTH_WORDS];

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   lane_mask = 4'b0001 << lane;
            2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   extract_load = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   extract_load = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: extract_load = word;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    endfunction

    assign misalign_s = misaligned(cur_size_s, cur_addr_s[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // With zero wait states RESP is entered straight from IDLE, so the live inputs are the request
    assign cur_wr_s       = (state_r == ST_IDLE) ? wr_en         : wr_en_r;
    assign cur_addr_s     = (state_r == ST_IDLE) ? addr[BW-1:0]  : addr_r;
    assign cur_wdata_s    = (state_r == ST_IDLE) ? mem_write     : wdata_r;
    assign cur_size_s     = (state_r == ST_IDLE) ? size          : size_r;
    assign cur_unsigned_s = (state_r == ST_IDLE) ? load_unsigned : unsigned_r;
    assign cur_idx_s      = cur_addr_s[BW-1:2];
    assign lane_mask_s    = lane_mask(cur_size_s, cur_addr_s[1:0]);
    assign lane_data_s    = lane_data(cur_size_s, cur_wdata_s);
    assign rd_word_s      = mem_r[cur_idx_s];
    assign load_data_s    = extract_load(rd_word_s, cur_size_s, cur_addr_s[1:0], cur_unsigned_s);
    assign enter_resp_s   = (next_state_s == ST_RESP);
    assign unused_addr_s  = ^addr[31:BW];

    // Next-state logic for the request sequencer
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s     = 1'b1;
                    next_state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, latched request, wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            wr_en_r    <= 1'b0;
            addr_r     <= {BW{1'b0}};
            wdata_r    <= 32'h0000_0000;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            mem_read_r <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                wr_en_r    <= wr_en;
                addr_r     <= addr[BW-1:0];
                wdata_r    <= mem_write;
                size_r     <= size;
                unsigned_r <= load_unsigned;
                cnt_r      <= WAIT_INIT;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            ready_r <= enter_resp_s;
            busy_r  <= (next_state_s != ST_IDLE);
            err_r   <= enter_resp_s & misalign_s;
            // Store responses keep the previous load data unless flagged
            if (enter_resp_s) begin
                if (misalign_s) begin
                    mem_read_r <= 32'h0000_0000;
                end else if (!cur_wr_s) begin
                    mem_read_r <= load_data_s;
                end
            end
        end
    end

    // Byte-lane store commit on the edge entering RESP; storage is never cleared
    always_ff @(posedge clk) begin
        if (!rst && enter_resp_s && cur_wr_s && !misalign_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask_s[i]) begin
                    mem_r[cur_idx_s][i*8 +: 8] <= lane_data_s[i*8 +: 8];
                end
            end
        end
    end

    assign mem_read = mem_read_r;
    assign ready    = ready_r;
    assign err      = err_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan, randomized accesses against a byte-array model,
// ignored requests while busy, and reset during a wait state.
module tb_dmem_responder;

    localparam int WS = 1;
    localparam int DW = 1024;
    localparam int EXP_LAT = WS + 1;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
    localparam logic [31:0] HALF_EXP = 32'h1234BEEF;
`else
    localparam bit CHECK_EN = 1'b0;
    localparam logic [31:0] HALF_EXP = 32'h12345678;
`endif

    logic        clk = 1'b0;
    logic        rst, req, wr_en, load_unsigned;
    logic [31:0] addr, mem_write, mem_read;
    logic [1:0]  size;
    logic        ready, err, busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] exp;
    } op_t;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .addr(addr),
        .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned),
        .mem_read(mem_read), .ready(ready), .err(err), .busy(busy)
    );

    function automatic bit model_misalign(input logic [31:0] a, input logic [1:0] sz);
        return CHECK_EN && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
    endfunction

    // Reference: memory as a flat byte array addressed modulo DW*4
    task automatic model_op(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input bit uns, output logic [31:0] exp_rd, output logic exp_err);
        int b, hb, wb;
        logic [31:0] v;
        b  = int'(a % (DW * 4));
        hb = b - (b % 2);
        wb = b - (b % 4);
        exp_err = model_misalign(a, sz);
        if (exp_err) begin
            exp_rd = 32'h0;
        end else if (wr) begin
            if (sz == 2'b00) ref_mem[b] = d[7:0];
            else if (sz == 2'b01) begin
                ref_mem[hb] = d[7:0]; ref_mem[hb+1] = d[15:8];
            end else begin
                ref_mem[wb] = d[7:0]; ref_mem[wb+1] = d[15:8]; ref_mem[wb+2] = d[23:16]; ref_mem[wb+3] = d[31:24];
            end
            exp_rd = last_rd;
        end else begin
            if (sz == 2'b00) begin
                v = 32'(ref_mem[b]);
                if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
            end else if (sz == 2'b01) begin
                v = 32'(ref_mem[hb]) + 32'(ref_mem[hb+1]) * 32'd256;
                if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
            end else begin
                v = 32'(ref_mem[wb]) + 32'(ref_mem[wb+1]) * 32'd256 + 32'(ref_mem[wb+2]) * 32'd65536
                    + 32'(ref_mem[wb+3]) * 32'd16777216;
            end
            exp_rd = v;
        end
        last_rd = exp_rd;
    endtask

    // Issue one request and observe the response (no checking here)
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             input bit uns, output logic [31:0] rd, output logic er, output int lat,
                             output logic [1:0] post, output bit busy_ok);
        @(negedge clk);
        req = 1'b1; wr_en = wr; addr = a; mem_write = d; size = sz; load_unsigned = uns;
        @(posedge clk); #1;
        req = 1'b0; wr_en = 1'($urandom); addr = $urandom; mem_write = $urandom;
        size = 2'($urandom); load_unsigned = 1'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (ready !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        rd = mem_read;
        er = err;
        @(posedge clk); #1;
        post = {ready, busy};
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp_rd, d;
        logic er, exp_err;
        logic [1:0] post;
        int lat;
        bit bok;
        rst = 1'b1; req = 1'b0; wr_en = 1'b0; addr = 32'h0; mem_write = 32'h0; size = 2'b00; load_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (mem_read !== 32'h0) begin n_fail++; $display("FAIL reset_mem_read got %h want 0", mem_read); end
        rst = 1'b0;
        last_rd = 32'h0;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            model_op(1'b1, 32'(w * 4), d, 2'b10, 1'b0, exp_rd, exp_err);
            do_access(1'b1, 32'(w * 4), d, 2'b10, 1'b0, rd, er, lat, post, bok);
            n_checks += 3;
            if (lat != EXP_LAT) begin n_fail++; $display("FAIL init_latency got %0d want %0d", lat, EXP_LAT); end
            if (rd !== exp_rd) begin n_fail++; $display("FAIL init_store_rd got %h want %h", rd, exp_rd); end
            if (post !== 2'b00) begin n_fail++; $display("FAIL init_post got %b want 00", post); end
        end
    endtask

    task automatic test_directed();
        op_t ops[12];
        logic [31:0] rd, exp_rd;
        logic er, exp_err;
        logic [1:0] post;
        int lat;
        bit bok;
        ops = '{
            '{1'b1, 32'h10,   32'hDEADBEEF, 2'b10, 1'b0, 32'h0},
            '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF},
            '{1'b1, 32'h13,   32'h80,       2'b00, 1'b0, 32'h0},
            '{1'b0, 32'h13,   32'h0,        2'b00, 1'b0, 32'hFFFFFF80},
            '{1'b0, 32'h13,   32'h0,        2'b00, 1'b1, 32'h00000080},
            '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'h80ADBEEF},
            '{1'b1, 32'h12,   32'h1234,     2'b01, 1'b0, 32'h0},
            '{1'b0, 32'h12,   32'h0,        2'b01, 1'b0, 32'h00001234},
            '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'h1234BEEF},
            '{1'b1, 32'h11,   32'h5678,     2'b01, 1'b0, 32'h0},
            '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, HALF_EXP},
            '{1'b0, 32'h1010, 32'h0,        2'b10, 1'b0, HALF_EXP}
        };
        for (int i = 0; i < 12; i++) begin
            model_op(ops[i].wr, ops[i].a, ops[i].d, ops[i].sz, ops[i].uns, exp_rd, exp_err);
            do_access(ops[i].wr, ops[i].a, ops[i].d, ops[i].sz, ops[i].uns, rd, er, lat, post, bok);
            n_checks += 5;
            if (lat != EXP_LAT) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, EXP_LAT); end
            if (rd !== exp_rd) begin n_fail++; $display("FAIL dir%0d_rd got %h want %h", i, rd, exp_rd); end
            if (er !== exp_err) begin n_fail++; $display("FAIL dir%0d_err got %b want %b", i, er, exp_err); end
            if (post !== 2'b00) begin n_fail++; $display("FAIL dir%0d_post got %b want 00", i, post); end
            if (!bok) begin n_fail++; $display("FAIL dir%0d_busy got 0 want 1 while pending", i); end
            if (!ops[i].wr) begin
                n_checks++;
                if (rd !== ops[i].exp) begin n_fail++; $display("FAIL dir%0d_plan got %h want %h", i, rd, ops[i].exp); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, a, d;
        logic er, exp_err;
        logic [1:0] post, sz;
        int lat;
        bit bok, wr, uns;
        for (int i = 0; i < 150; i++) begin
            wr  = 1'($urandom);
            a   = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            d   = $urandom;
            sz  = 2'($urandom);
            uns = 1'($urandom);
            model_op(wr, a, d, sz, uns, exp_rd, exp_err);
            do_access(wr, a, d, sz, uns, rd, er, lat, post, bok);
            n_checks += 5;
            if (lat != EXP_LAT) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, EXP_LAT); end
            if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rd a=%h sz=%0d wr=%0d got %h want %h", i, a, sz, wr, rd, exp_rd); end
            if (er !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", i, er, exp_err); end
            if (post !== 2'b00) begin n_fail++; $display("FAIL rnd%0d_post got %b want 00", i, post); end
            if (!bok) begin n_fail++; $display("FAIL rnd%0d_busy got 0 want 1 while pending", i); end
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] exp_rd, rd, cap;
        logic exp_err, er;
        logic [1:0] post;
        int lat, nready;
        bit bok;
        model_op(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, exp_rd, exp_err);
        @(negedge clk);
        req = 1'b1; wr_en = 1'b0; addr = 32'h20; mem_write = 32'h0; size = 2'b10; load_unsigned = 1'b0;
        @(posedge clk); #1;
        // A stray store pulsed while busy must be dropped
        wr_en = 1'b1; addr = 32'h30; mem_write = 32'hA5A5A5A5;
        nready = 0;
        cap = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) req = 1'b0;
            if (ready === 1'b1) begin nready++; cap = mem_read; end
        end
        n_checks += 2;
        if (nready != 1) begin n_fail++; $display("FAIL ignore_ready_count got %0d want 1", nready); end
        if (cap !== exp_rd) begin n_fail++; $display("FAIL ignore_rd got %h want %h", cap, exp_rd); end
        model_op(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, exp_rd, exp_err);
        do_access(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd, er, lat, post, bok);
        n_checks++;
        if (rd !== exp_rd) begin n_fail++; $display("FAIL ignore_mem_unchanged got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] exp_rd, rd;
        logic exp_err, er;
        logic [1:0] post;
        int lat, nready;
        bit bok;
        @(negedge clk);
        req = 1'b1; wr_en = 1'b1; addr = 32'h20; mem_write = 32'hCAFEF00D; size = 2'b10; load_unsigned = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstwait_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks += 4;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL rstwait_ready got %b want 0", ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy got %b want 0", busy); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL rstwait_err got %b want 0", err); end
        if (mem_read !== 32'h0) begin n_fail++; $display("FAIL rstwait_mem_read got %h want 0", mem_read); end
        last_rd = 32'h0;
        nready = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) nready++;
        end
        n_checks++;
        if (nready != 0) begin n_fail++; $display("FAIL rstwait_no_ready got %0d want 0", nready); end
        model_op(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, exp_rd, exp_err);
        do_access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat, post, bok);
        n_checks += 2;
        if (rd !== exp_rd) begin n_fail++; $display("FAIL rstwait_old_value got %h want %h", rd, exp_rd); end
        if (lat != EXP_LAT) begin n_fail++; $display("FAIL rstwait_latency got %0d want %0d", lat, EXP_LAT); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
